flag_branch_unit: RTL and testbench
===================================

Name: flag_branch_unit

Overview:
Consumer side of the 4-bit FLAGS register. Accepts a conditional-branch request from the control unit, waits until no flag-writing ALU op is in flight, samples FLAGS, evaluates a 4-bit condition code, and drives a one-cycle PC load with either the branch target or the fall-through address. It also keeps saturating branch statistics counters.

Parameters:
AW, 16, width of PC, target and next-PC buses
CW, 16, width of each statistics counter
PC_INC, 1, fall-through increment added to pc

Ports:
clk  in  1  system clock, rising edge
rst_b  in  1  asynchronous active-low reset
flags  in  4  FLAGS register output; [3]=N, [2]=Z, [1]=C, [0]=V
flags_busy  in  1  high while an ALU op that will write FLAGS is in flight
req_valid  in  1  branch request valid
req_ready  out  1  unit can accept a request (high only in IDLE)
req_cond  in  4  condition code
req_target  in  AW  branch target address
req_pc  in  AW  address of the branch instruction
pc_ld  out  1  one-cycle PC load strobe
pc_next  out  AW  value to load into PC, valid when pc_ld=1
taken  out  1  branch outcome, valid when pc_ld=1
stat_clr  in  1  synchronous clear of both counters
cnt_total  out  CW  branches resolved, saturating
cnt_taken  out  CW  branches taken, saturating

Behaviour:
- Reset (asynchronous, rst_b=0): state=IDLE; req_ready=1; pc_ld=0, pc_next=0, taken=0; cnt_total=cnt_taken=0; internal cond/target/pc/flag latches=0. Asserting reset mid-operation aborts the request, and no pc_ld is issued for it.
- FSM states: IDLE, WAIT_FLAGS, EVAL, UPDATE.
- IDLE: req_ready=1. When req_valid=1, latch cond, target and pc. Go to WAIT_FLAGS if flags_busy=1, otherwise go to EVAL.
- WAIT_FLAGS: req_ready=0. Stay while flags_busy=1. Go to EVAL in the first cycle that flags_busy=0. There is no timeout.
- EVAL: register flags into flag_q, compute cond_true, then go to UPDATE. Flags are sampled only here. Changes to flags in later cycles do not affect the outcome.
- UPDATE: pc_ld=1 for exactly one cycle. taken=cond_true. pc_next=taken ? target : pc+PC_INC (mod 2^AW, so wrap-around is allowed). Return to IDLE.
- pc_next and taken hold their values after pc_ld falls, until the next UPDATE.
- Latency without a stall: request accepted at edge T, EVAL in cycle T+1, pc_ld high in cycle T+2. Each stall cycle in WAIT_FLAGS adds one cycle.
- Throughput: at most one request per 3 cycles. req_valid outside IDLE is ignored. The requester holds req_valid until it sees req_ready.
- Condition decode:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F NV: 0
- Counters update in the UPDATE cycle. cnt_total+1, and cnt_taken+1 if taken. Each counter saturates at 2^CW-1 and holds there.
- stat_clr=1 zeroes both counters at the next edge. If it coincides with UPDATE, the clear wins and the counters read 0.

Decomposition:
- Shared package: condition-code constants (COND_EQ..COND_NV), FLAGS bit indices (FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0), and FSM state encodings.
- Sub-module cond_decode: purely combinational; inputs flags[3:0] and cond[3:0], output cond_true. It is reused by any future conditional-execution logic.

Test Plan:
- Reset: hold rst_b=0 for 3 cycles, release -> req_ready=1, pc_ld=0, pc_next=0, cnt_total=cnt_taken=0.
- Basic taken: flags=4'b0100, cond=0 (EQ), target=0x0040, pc=0x0010, flags_busy=0 -> pc_ld high 2 cycles after accept, pc_next=0x0040, taken=1, cnt_taken=1.
- Not taken with wrap: flags=4'b0000, cond=0 (EQ), pc=0xFFFF -> pc_next=0x0000, taken=0, cnt_total=1, cnt_taken=0.
- Stall:
  - Setup: flags_busy=1 for 4 cycles after accept; flags change from 0000 to 1001 on the last busy cycle; cond=A (GE).
  - Check: pc_ld appears 6 cycles after accept, taken=1 (N==V).
  - Check: changing flags to 0001 during UPDATE has no effect on taken.
- Exhaustive decode: sweep all 16 cond × 16 flag values through full requests -> taken matches the reference table in every case; AL is always taken, NV is never taken.
- Reset and saturation:
  - Drop rst_b during WAIT_FLAGS -> no pc_ld, state returns to IDLE.
  - CW=4: 17 AL branches -> cnt_total=cnt_taken=15.
  - stat_clr in the same cycle as UPDATE -> counters read 0.

Source files
------------

// File: rtl/flag_branch_unit_pkg.sv
// Shared definitions for the branch-resolution slice: condition codes,
// FLAGS bit positions and the resolver FSM state encoding.
package flag_branch_unit_pkg;

  // Condition codes carried on req_cond
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Bit positions inside the 4-bit FLAGS register
  localparam int unsigned FLG_N = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FLAGS = 2'd1,
    ST_EVAL       = 2'd2,
    ST_UPDATE     = 2'd3
  } state_e;

endpackage

// File: rtl/flag_branch_unit_cond_decode.sv
// Combinational condition-code evaluator.
// Ports: flags[3:0] (N,Z,C,V), cond[3:0] condition code, cond_true result.
module flag_branch_unit_cond_decode
  import flag_branch_unit_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       cond_true
);

  logic n, z, c, v;

  assign n = flags[FLG_N];
  assign z = flags[FLG_Z];
  assign c = flags[FLG_C];
  assign v = flags[FLG_V];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = !z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = !c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = !n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = !v;
      COND_HI: cond_true = c && !z;
      COND_LS: cond_true = !c || z;
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = !z && (n == v);
      COND_LE: cond_true = z || (n != v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Conditional-branch resolver: accepts a branch request, waits for in-flight
// flag writers to drain, samples FLAGS once, and issues a one-cycle PC load
// with the target or fall-through address. Keeps saturating statistics.
// Ports: clk/rst_b; flags, flags_busy from the ALU; req_* handshake from
// control; pc_ld/pc_next/taken to the PC; stat_clr, cnt_total, cnt_taken.
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter int unsigned AW     = 16,
  parameter int unsigned CW     = 16,
  parameter int unsigned PC_INC = 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic [3:0]    flags,
  input  logic          flags_busy,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_cond,
  input  logic [AW-1:0] req_target,
  input  logic [AW-1:0] req_pc,
  output logic          pc_ld,
  output logic [AW-1:0] pc_next,
  output logic          taken,
  input  logic          stat_clr,
  output logic [CW-1:0] cnt_total,
  output logic [CW-1:0] cnt_taken
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e        state;
  logic [3:0]    cond_q;
  logic [3:0]    flag_q;
  logic [AW-1:0] target_q;
  logic [AW-1:0] pc_q;
  logic [3:0]    dec_flags;
  logic          cond_true;

  // Live FLAGS are looked at only in EVAL; afterwards the latched copy is used
  // so later flag writes cannot disturb the outcome.
  assign dec_flags = (state == ST_EVAL) ? flags : flag_q;

  flag_branch_unit_cond_decode u_cond_decode (
    .flags     (dec_flags),
    .cond      (cond_q),
    .cond_true (cond_true)
  );

  // Resolver FSM, registered outputs and statistics counters
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      pc_ld     <= 1'b0;
      pc_next   <= '0;
      taken     <= 1'b0;
      cond_q    <= '0;
      flag_q    <= '0;
      target_q  <= '0;
      pc_q      <= '0;
      cnt_total <= '0;
      cnt_taken <= '0;
    end else begin
      pc_ld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cond_q    <= req_cond;
            target_q  <= req_target;
            pc_q      <= req_pc;
            req_ready <= 1'b0;
            state     <= flags_busy ? ST_WAIT_FLAGS : ST_EVAL;
          end
        end
        ST_WAIT_FLAGS: begin
          if (!flags_busy) state <= ST_EVAL;
        end
        ST_EVAL: begin
          // Outcome is registered here so it is presented alongside pc_ld
          flag_q  <= flags;
          taken   <= cond_true;
          pc_next <= cond_true ? target_q : pc_q + AW'(PC_INC);
          pc_ld   <= 1'b1;
          state   <= ST_UPDATE;
        end
        ST_UPDATE: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase

      // Clear takes priority over a coincident update
      if (stat_clr) begin
        cnt_total <= '0;
        cnt_taken <= '0;
      end else if (state == ST_UPDATE) begin
        if (cnt_total != CNT_MAX) cnt_total <= cnt_total + CW'(1);
        if (cond_true && (cnt_taken != CNT_MAX)) cnt_taken <= cnt_taken + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
module tb_flag_branch_unit;

  localparam int unsigned AW = 16;
  localparam int unsigned CW = 4;
  localparam int CMAX = 15;

  logic          clk;
  logic          rst_b;
  logic [3:0]    flags;
  logic          flags_busy;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_cond;
  logic [AW-1:0] req_target;
  logic [AW-1:0] req_pc;
  logic          pc_ld;
  logic [AW-1:0] pc_next;
  logic          taken;
  logic          stat_clr;
  logic [CW-1:0] cnt_total;
  logic [CW-1:0] cnt_taken;

  flag_branch_unit #(.AW(AW), .CW(CW), .PC_INC(1)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .flags      (flags),
    .flags_busy (flags_busy),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cond   (req_cond),
    .req_target (req_target),
    .req_pc     (req_pc),
    .pc_ld      (pc_ld),
    .pc_next    (pc_next),
    .taken      (taken),
    .stat_clr   (stat_clr),
    .cnt_total  (cnt_total),
    .cnt_taken  (cnt_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int m_total  = 0;
  int m_taken  = 0;

  typedef struct {
    logic [3:0]  cond;
    logic [3:0]  flags0;
    logic [15:0] target;
    logic [15:0] pc;
    int          nbusy;
    int          chg_k;
    logic [3:0]  flags1;
    bit          exp_taken;
    logic [15:0] exp_pc;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Branch condition from the architectural flag definitions
  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One full request; flags change to flags1 at cycle chg_k (0 = never),
  // and are scrambled to upd_f while pc_ld is high.
  task automatic run_check(input vec_t vv, input logic [3:0] upd_f, input bit clr_upd);
    int guard;
    int k;
    bit done;
    logic [15:0] got_pc;
    bit got_t;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_cond   = vv.cond;
    req_target = vv.target;
    req_pc     = vv.pc;
    flags      = vv.flags0;
    flags_busy = (vv.nbusy > 0);
    @(posedge clk);
    k = 0;
    done = 0;
    got_pc = '0;
    got_t = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        req_valid = 1'b0;
        chk("ready_low_after_accept", 32'(req_ready), 32'd0);
      end
      if (pc_ld) begin
        done   = 1;
        got_pc = pc_next;
        got_t  = taken;
        flags  = upd_f;
        if (clr_upd) stat_clr = 1'b1;
      end else begin
        flags_busy = (k < vv.nbusy);
        if (k == vv.chg_k) flags = vv.flags1;
      end
    end
    chk("pc_ld_seen", 32'(done), 32'd1);
    chk("latency", 32'(k), 32'(vv.exp_lat));
    chk("taken", 32'(got_t), 32'(vv.exp_taken));
    chk("pc_next", 32'(got_pc), 32'(vv.exp_pc));
    if (clr_upd) begin
      m_total = 0;
      m_taken = 0;
    end else begin
      if (m_total < CMAX) m_total++;
      if (vv.exp_taken && m_taken < CMAX) m_taken++;
    end
    @(negedge clk);
    stat_clr = 1'b0;
    chk("pc_ld_one_cycle", 32'(pc_ld), 32'd0);
    chk("taken_hold", 32'(taken), 32'(vv.exp_taken));
    chk("pc_next_hold", 32'(pc_next), 32'(vv.exp_pc));
    chk("cnt_total", 32'(cnt_total), 32'(m_total));
    chk("cnt_taken", 32'(cnt_taken), 32'(m_taken));
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [3:0] f0,
                              input logic [15:0] tgt, input logic [15:0] pcv,
                              input int nb, input int ck, input logic [3:0] f1);
    vec_t r;
    logic [3:0] fe;
    r.cond = c; r.flags0 = f0; r.target = tgt; r.pc = pcv;
    r.nbusy = nb; r.chg_k = ck; r.flags1 = f1;
    fe = (ck >= 1 && ck <= nb + 1) ? f1 : f0;
    r.exp_taken = ref_cond(c, fe);
    r.exp_pc = r.exp_taken ? tgt : 16'(pcv + 16'd1);
    r.exp_lat = 2 + nb;
    return r;
  endfunction

  vec_t tbl[7];
  vec_t rv;
  bit   seen_ld;

  initial begin
    // Directed vectors with hand-derived expectations
    tbl[0] = '{4'h0, 4'b0100, 16'h0040, 16'h0010, 0, 0, 4'b0000, 1'b1, 16'h0040, 2};
    tbl[1] = '{4'h0, 4'b0000, 16'h1234, 16'hFFFF, 0, 0, 4'b0000, 1'b0, 16'h0000, 2};
    tbl[2] = '{4'hA, 4'b0000, 16'h0200, 16'h0100, 4, 3, 4'b1001, 1'b1, 16'h0200, 6};
    tbl[3] = '{4'h8, 4'b0010, 16'h0300, 16'h0050, 1, 0, 4'b0000, 1'b1, 16'h0300, 3};
    tbl[4] = '{4'hD, 4'b1000, 16'h0400, 16'h0060, 2, 0, 4'b0000, 1'b1, 16'h0400, 4};
    tbl[5] = '{4'hF, 4'b1111, 16'h0500, 16'h0070, 0, 0, 4'b0000, 1'b0, 16'h0071, 2};
    tbl[6] = '{4'hC, 4'b0100, 16'h0600, 16'h0080, 0, 0, 4'b0000, 1'b0, 16'h0081, 2};

    rst_b = 1'b0; flags = '0; flags_busy = 1'b0; req_valid = 1'b0;
    req_cond = '0; req_target = '0; req_pc = '0; stat_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_pc_ld", 32'(pc_ld), 32'd0);
    chk("rst_pc_next", 32'(pc_next), 32'd0);
    chk("rst_taken", 32'(taken), 32'd0);
    chk("rst_cnt_total", 32'(cnt_total), 32'd0);
    chk("rst_cnt_taken", 32'(cnt_taken), 32'd0);
    rst_b = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_check(tbl[i], 4'b0001, 1'b0);

    // Randomized requests against the reference model
    for (int i = 0; i < 150; i++) begin
      int nb;
      nb = int'($urandom_range(0, 3));
      rv = mk(4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
              nb, int'($urandom_range(0, nb + 1)), 4'($urandom));
      run_check(rv, 4'($urandom), 1'b0);
    end

    // Exhaustive condition x flags sweep
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        rv = mk(4'(c), 4'(f), 16'h8000, 16'(c * 16 + f), 0, 0, 4'b0000);
        run_check(rv, ~4'(f), 1'b0);
      end
    end

    // Clear coinciding with UPDATE wins
    rv = mk(4'hE, 4'b0000, 16'h0abc, 16'h0001, 0, 0, 4'b0000);
    run_check(rv, 4'b0000, 1'b1);
    chk("clr_in_update_total", 32'(cnt_total), 32'd0);
    chk("clr_in_update_taken", 32'(cnt_taken), 32'd0);

    // Saturation: 17 always-taken branches from zero
    for (int i = 0; i < 17; i++) begin
      rv = mk(4'hE, 4'($urandom), 16'(i), 16'h1000, 0, 0, 4'b0000);
      run_check(rv, 4'b0000, 1'b0);
    end
    chk("sat_total", 32'(cnt_total), 32'd15);
    chk("sat_taken", 32'(cnt_taken), 32'd15);

    // Reset while stalled in WAIT_FLAGS aborts the request
    req_valid = 1'b1; req_cond = 4'hE; req_target = 16'h7777; req_pc = 16'h0002;
    flags_busy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("stall_no_ld", 32'(pc_ld), 32'd0);
    rst_b = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_pc_ld", 32'(pc_ld), 32'd0);
    chk("midrst_cnt_total", 32'(cnt_total), 32'd0);
    m_total = 0; m_taken = 0;
    @(negedge clk);
    rst_b = 1'b1;
    flags_busy = 1'b0;
    seen_ld = 0;
    repeat (6) begin
      @(negedge clk);
      if (pc_ld) seen_ld = 1;
    end
    chk("midrst_no_ld", 32'(seen_ld), 32'd0);
    chk("midrst_idle", 32'(req_ready), 32'd1);

    // Unit still works after the abort
    run_check(tbl[0], 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
